// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and helpers for the dual-port masked SRAM
//
// Purpose : read-during-write mode codes, clear sequencer state type,
//           lane-count and lane-merge helpers shared by sram_dp_mask and
//           sram_clr_seq.
// Ports   : none (package).

package sram_pkg;

  // Same-address same-cycle read/write behaviour
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest word lane_merge can handle; callers zero-extend into this width
  localparam int MAXW = 256;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_BUSY = 1'b1
  } clr_state_e;

  function automatic int nlane(input int dbits, input int lbits);
    return dbits / lbits;
  endfunction

  // Bit i of the result comes from new_w when the lane holding bit i is
  // enabled in mask, otherwise from old_w.
  function automatic logic [MAXW-1:0] lane_merge(
    input logic [MAXW-1:0] old_w,
    input logic [MAXW-1:0] new_w,
    input logic [MAXW-1:0] mask,
    input int              lbits
  );
    logic [MAXW-1:0] r;
    for (int i = 0; i < MAXW; i++) begin
      r[i] = mask[i / lbits] ? new_w[i] : old_w[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_clr_seq.sv
// rtl/sram_clr_seq.sv - zero-fill sequencer for the dual-port masked SRAM
//
// Purpose : on a clr request walks every address once, one word per cycle,
//           driving a write port that the top muxes over the user port.
// Ports   :
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset
//   clr       in   start request, sampled only while idle
//   clr_busy  out  sweep in progress (registered)
//   clr_we    out  clear write enable for the array
//   clr_addr  out  address being cleared this cycle

module sram_clr_seq
  import sram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int ABITS = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  output logic             clr_busy,
  output logic             clr_we,
  output logic [ABITS-1:0] clr_addr
);

  localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(DEPTH - 1);

  clr_state_e       state;
  logic [ABITS-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= CLR_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (clr) begin
            state    <= CLR_BUSY;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLR_BUSY: begin
          // clr is deliberately ignored here: a sweep never restarts
          if (cnt == LAST_ADDR) begin
            state    <= CLR_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= CLR_IDLE;
          cnt      <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Every busy cycle writes exactly one word, so the enable is the busy flag
  assign clr_we   = clr_busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/sram_dp_mask.sv
// rtl/sram_dp_mask.sv - simple-dual-port SRAM with lane write mask and clear
//
// Purpose : one write port with per-lane mask, one read port with latency
//           1+OREG, selectable read-during-write result, and a sequencer
//           that zero-fills (CLR_VAL) the whole array on request.
// Ports   :
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset
//   wr        in   write request
//   waddr     in   write address (>= DEPTH is dropped)
//   wdat      in   write data
//   wmask     in   lane enables, bit i covers wdat[i*LBITS +: LBITS]
//   rd        in   read request
//   raddr     in   read address (>= DEPTH reads back 0)
//   rdat      out  read data, held between reads
//   rvld      out  one-cycle strobe per completed read
//   clr       in   start clear
//   clr_busy  out  clear in progress, user wr/rd ignored

module sram_dp_mask
  import sram_pkg::*;
#(
  parameter int               DBITS    = 32,
  parameter int               LBITS    = 8,
  parameter int               DEPTH    = 256,
  parameter int               OREG     = 0,
  parameter int               RDW_MODE = RDW_OLD,
  parameter logic [DBITS-1:0] CLR_VAL  = '0,
  parameter int               NLANE    = nlane(DBITS, LBITS),
  parameter int               ABITS    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr,
  input  logic [ABITS-1:0] waddr,
  input  logic [DBITS-1:0] wdat,
  input  logic [NLANE-1:0] wmask,
  input  logic             rd,
  input  logic [ABITS-1:0] raddr,
  output logic [DBITS-1:0] rdat,
  output logic             rvld,
  input  logic             clr,
  output logic             clr_busy
);

  // DEPTH in one extra bit so a full power-of-two depth still compares
  localparam logic [ABITS:0] DEPTH_W = (ABITS + 1)'(DEPTH);

  function automatic logic [DBITS-1:0] merge(
    input logic [DBITS-1:0] old_w,
    input logic [DBITS-1:0] new_w,
    input logic [NLANE-1:0] m
  );
    logic [MAXW-1:0] r;
    r = lane_merge(MAXW'(old_w), MAXW'(new_w), MAXW'(m), LBITS);
    return r[DBITS-1:0];
  endfunction

  logic [DBITS-1:0] mem [DEPTH];

  logic             seq_busy;
  logic             clr_we;
  logic [ABITS-1:0] clr_addr;

  sram_clr_seq #(
    .DEPTH (DEPTH),
    .ABITS (ABITS)
  ) u_clr_seq (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .clr_busy (seq_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign clr_busy = seq_busy;

  logic             waddr_ok;
  logic             raddr_ok;
  logic             w_ok;
  logic             r_ok;
  logic [DBITS-1:0] w_old;
  logic [DBITS-1:0] w_merged;
  logic [DBITS-1:0] r_data;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_W);
  // An all-zero mask is treated as no write so it cannot disturb the array
  assign w_ok     = wr && !seq_busy && waddr_ok && (|wmask);
  assign r_ok     = rd && !seq_busy;

  always_comb begin
    w_old    = mem[waddr];
    w_merged = merge(w_old, wdat, wmask);
    r_data   = '0;
    if (raddr_ok) begin
      // New-data mode forwards the merged word that this same edge writes
      if (RDW_MODE == RDW_NEW && w_ok && waddr == raddr) begin
        r_data = w_merged;
      end else begin
        r_data = mem[raddr];
      end
    end
  end

  // Array has no reset; the clear port takes priority over the user port
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLR_VAL;
    end else if (w_ok) begin
      mem[waddr] <= w_merged;
    end
  end

  logic [DBITS-1:0] s1_dat;
  logic             s1_vld;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_dat <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= r_ok;
      if (r_ok) begin
        s1_dat <= r_data;
      end
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [DBITS-1:0] s2_dat;
      logic             s2_vld;

      // Not gated by clr_busy so reads in flight when a clear starts finish
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s2_dat <= '0;
          s2_vld <= 1'b0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_dat <= s1_dat;
          end
        end
      end

      assign rdat = s2_dat;
      assign rvld = s2_vld;
    end else begin : g_noreg
      assign rdat = s1_dat;
      assign rvld = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_sram_dp_mask.sv
// tb/tb_sram_dp_mask.sv - scoreboard bench for two sram_dp_mask configurations

module tb_sram_dp_mask;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr, rd, clr;
  logic [7:0]  waddr, raddr;
  logic [31:0] wdat;
  logic [3:0]  wmask;

  logic [31:0] rdat_a, rdat_b;
  logic        rvld_a, rvld_b, busy_a, busy_b;

  always #5 clk = ~clk;

  // a: DEPTH=200, output register, new-data RDW; b: defaults
  sram_dp_mask #(
    .DBITS(32), .LBITS(8), .DEPTH(200), .OREG(1), .RDW_MODE(1), .CLR_VAL(32'h0)
  ) u_a (
    .clk(clk), .rstn(rstn), .wr(wr), .waddr(waddr), .wdat(wdat), .wmask(wmask),
    .rd(rd), .raddr(raddr), .rdat(rdat_a), .rvld(rvld_a), .clr(clr), .clr_busy(busy_a)
  );

  sram_dp_mask #(
    .DBITS(32), .LBITS(8), .DEPTH(256), .OREG(0), .RDW_MODE(0), .CLR_VAL(32'h0)
  ) u_b (
    .clk(clk), .rstn(rstn), .wr(wr), .waddr(waddr), .wdat(wdat), .wmask(wmask),
    .rd(rd), .raddr(raddr), .rdat(rdat_b), .rvld(rvld_b), .clr(clr), .clr_busy(busy_b)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  exp_t        sb     [2][$];
  logic [31:0] mm     [2][256];
  int          m_busy [2];
  int          m_cnt  [2];
  logic [31:0] m_last [2];
  int          depth  [2] = '{200, 256};
  int          oreg   [2] = '{1, 0};
  int          rdw    [2] = '{1, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    end
    return r;
  endfunction

  // Apply the currently driven inputs to the model for the coming edge
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (m_busy[k] != 0) begin
        mm[k][m_cnt[k]] = 32'h0;
        if (m_cnt[k] == depth[k] - 1) begin
          m_busy[k] = 0;
          m_cnt[k]  = 0;
        end else begin
          m_cnt[k]++;
        end
      end else begin
        if (rd) begin
          exp_t e;
          e.due = cyc + 1 + oreg[k];
          if (int'(raddr) >= depth[k])
            e.d = 32'h0;
          else if (rdw[k] != 0 && wr && waddr == raddr)
            e.d = tb_merge(mm[k][raddr], wdat, wmask);
          else
            e.d = mm[k][raddr];
          sb[k].push_back(e);
        end
        if (wr && int'(waddr) < depth[k]) mm[k][waddr] = tb_merge(mm[k][waddr], wdat, wmask);
        if (clr) begin
          m_busy[k] = 1;
          m_cnt[k]  = 0;
        end
      end
    end
  endtask

  task automatic check_outs();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] rdt;
      logic        rv, bs;
      string       p;
      rdt = (k == 0) ? rdat_a : rdat_b;
      rv  = (k == 0) ? rvld_a : rvld_b;
      bs  = (k == 0) ? busy_a : busy_b;
      p   = (k == 0) ? "a" : "b";
      if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
        exp_t e;
        e = sb[k].pop_front();
        m_last[k] = e.d;
        chk({p, "_rvld"}, 32'(rv), 32'h1);
        chk({p, "_rdat"}, rdt, e.d);
      end else begin
        chk({p, "_rvld_idle"}, 32'(rv), 32'h0);
        chk({p, "_rdat_hold"}, rdt, m_last[k]);
      end
      chk({p, "_clr_busy"}, 32'(bs), 32'(m_busy[k]));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outs();
    @(negedge clk);
  endtask

  task automatic op(input bit w, input int wa, input logic [31:0] wd, input logic [3:0] wm,
                    input bit r, input int ra, input bit c);
    wr    = w;
    waddr = 8'(wa);
    wdat  = wd;
    wmask = wm;
    rd    = r;
    raddr = 8'(ra);
    clr   = c;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(0, 0, 32'h0, 4'h0, 0, 0, 0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0;
      m_cnt[k]  = 0;
      m_last[k] = 32'h0;
      sb[k].delete();
    end
  endtask

  initial begin
    model_reset();
    rstn = 1'b0;
    wr = 0; rd = 0; clr = 0; waddr = 0; raddr = 0; wdat = 0; wmask = 0;
    @(posedge clk);
    #1;
    chk("rst_rdat_a", rdat_a, 32'h0);
    chk("rst_rvld_a", 32'(rvld_a), 32'h0);
    chk("rst_busy_a", 32'(busy_a), 32'h0);
    chk("rst_rdat_b", rdat_b, 32'h0);
    chk("rst_rvld_b", 32'(rvld_b), 32'h0);
    chk("rst_busy_b", 32'(busy_b), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Full write, read back; partial mask; zero mask
    op(1, 5, 32'hA1B2C3D4, 4'hF, 0, 0, 0);
    op(0, 0, 32'h0, 4'h0, 1, 5, 0);
    op(1, 5, 32'h11223344, 4'b0101, 0, 0, 0);
    op(0, 0, 32'h0, 4'h0, 1, 5, 0);
    op(1, 5, 32'hDEADBEEF, 4'h0, 0, 0, 0);
    op(0, 0, 32'h0, 4'h0, 1, 5, 0);
    idle(2);

    // Same-edge read/write at address 7, full and partial masks
    op(1, 7, 32'h0, 4'hF, 0, 0, 0);
    op(1, 7, 32'hFFFFFFFF, 4'hF, 1, 7, 0);
    op(1, 7, 32'h12345678, 4'b0011, 1, 7, 0);
    op(0, 0, 32'h0, 4'h0, 1, 7, 0);
    idle(2);

    // Out-of-range on a (DEPTH=200), in range on b; last valid word
    op(1, 210, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    op(0, 0, 32'h0, 4'h0, 1, 210, 0);
    op(1, 199, 32'h0BADC0DE, 4'hF, 0, 0, 0);
    op(0, 0, 32'h0, 4'h0, 1, 199, 0);
    // Back-to-back reads
    op(0, 0, 32'h0, 4'h0, 1, 5, 0);
    op(0, 0, 32'h0, 4'h0, 1, 7, 0);
    op(0, 0, 32'h0, 4'h0, 1, 199, 0);
    idle(3);

    // Fill every word with a nonzero pattern
    for (int i = 0; i < 256; i++) op(1, i, 32'h5A000000 | (i << 8) | (255 - i), 4'hF, 0, 0, 0);

    // clr with same-edge read and write, then user traffic while busy
    op(1, 9, 32'h77777777, 4'hF, 1, 5, 1);
    for (int i = 0; i < 262; i++) begin
      if (i == 10)      op(1, 3, 32'h12121212, 4'hF, 1, 3, 0);
      else if (i == 20) op(0, 0, 32'h0, 4'h0, 0, 0, 1);
      else if (i == 150) op(1, 1, 32'h34343434, 4'hF, 1, 1, 0);
      else              idle(1);
    end
    for (int i = 0; i < 256; i++) op(0, 0, 32'h0, 4'h0, 1, i, 0);
    idle(3);

    // Async reset 100 cycles into a clear
    op(0, 0, 32'h0, 4'h0, 0, 0, 1);
    idle(99);
    rstn = 1'b0;
    #1;
    chk("abort_rdat_a", rdat_a, 32'h0);
    chk("abort_rvld_a", 32'(rvld_a), 32'h0);
    chk("abort_busy_a", 32'(busy_a), 32'h0);
    chk("abort_rdat_b", rdat_b, 32'h0);
    chk("abort_rvld_b", 32'(rvld_b), 32'h0);
    chk("abort_busy_b", 32'(busy_b), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    @(negedge clk);
    rstn = 1'b1;

    // Fresh clear must run exactly DEPTH cycles
    op(0, 0, 32'h0, 4'h0, 0, 0, 1);
    idle(260);
    op(0, 0, 32'h0, 4'h0, 1, 0, 0);
    op(0, 0, 32'h0, 4'h0, 1, 100, 0);
    op(0, 0, 32'h0, 4'h0, 1, 199, 0);
    op(0, 0, 32'h0, 4'h0, 1, 255, 0);
    idle(4);

    chk("a_sb_drained", 32'(sb[0].size()), 32'h0);
    chk("b_sb_drained", 32'(sb[1].size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
